// File: rtl/ex_stage.sv
// ex_stage: execute stage of the 16-bit pipeline.
// Evaluates single-cycle ALU ops and load/store addresses, and runs a
// DATA_W-iteration shift-add multiplier for MUL/MULH. The multiplier holds the
// upstream stages through the stall output. Results and controls are
// registered into the EX/MEM boundary.
module ex_stage #(
  parameter int DATA_W = 16,
  parameter int RD_W   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] reg_data1_in,
  input  logic [DATA_W-1:0] reg_data2_in,
  input  logic [DATA_W-1:0] imm_in,
  input  logic [RD_W-1:0]   rd_in,
  input  logic [3:0]        alu_op_in,
  input  logic              reg_write_in,
  input  logic              mem_read_in,
  input  logic              mem_write_in,
  input  logic              flush,
  output logic              stall,
  output logic [DATA_W-1:0] alu_result_out,
  output logic [DATA_W-1:0] store_data_out,
  output logic [RD_W-1:0]   rd_out,
  output logic              reg_write_out,
  output logic              mem_read_out,
  output logic              mem_write_out
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                state_reg;
  logic [2*DATA_W-1:0]   acc_reg;
  logic [2*DATA_W-1:0]   a_shift_reg;
  logic [DATA_W-1:0]     b_shift_reg;
  logic [DATA_W-1:0]     b_cap_reg;
  logic [CNT_W-1:0]      cnt_reg;
  logic [RD_W-1:0]       rd_cap_reg;
  logic                  rw_cap_reg;
  logic                  mr_cap_reg;
  logic                  mw_cap_reg;
  logic                  mulh_cap_reg;

  logic                  mem_access;
  logic                  is_mul;
  logic [CNT_W-1:0]      shamt;
  logic [DATA_W-1:0]     alu_result;

  // A memory access always computes an address, so it never starts a multiply.
  assign mem_access = mem_read_in | mem_write_in;
  assign is_mul     = ((alu_op_in == 4'hC) || (alu_op_in == 4'hD)) && !mem_access;
  assign shamt      = reg_data2_in[CNT_W-1:0];

  // Upstream is held while a MUL is being accepted or iterating; flush and
  // reset release the pipeline immediately.
  assign stall = reset && !flush &&
                 (((state_reg == IDLE) && is_mul) || (state_reg == BUSY));

  // Single-cycle ALU result, with the load/store address override.
  always_comb begin
    alu_result = '0;
    if (mem_access) begin
      alu_result = reg_data1_in + imm_in;
    end else begin
      case (alu_op_in)
        4'h0: alu_result = reg_data1_in + reg_data2_in;
        4'h1: alu_result = reg_data1_in - reg_data2_in;
        4'h2: alu_result = reg_data1_in & reg_data2_in;
        4'h3: alu_result = reg_data1_in | reg_data2_in;
        4'h4: alu_result = reg_data1_in ^ reg_data2_in;
        4'h5: alu_result = reg_data1_in << shamt;
        4'h6: alu_result = reg_data1_in >> shamt;
        4'h7: alu_result = $unsigned($signed(reg_data1_in) >>> shamt);
        4'h8: alu_result = {{(DATA_W-1){1'b0}}, ($signed(reg_data1_in) < $signed(reg_data2_in))};
        4'h9: alu_result = {{(DATA_W-1){1'b0}}, (reg_data1_in < reg_data2_in)};
        4'hA: alu_result = reg_data1_in + imm_in;
        4'hB: alu_result = imm_in;
        4'hE: alu_result = reg_data2_in;
        default: alu_result = '0;
      endcase
    end
  end

  // Multiplier FSM and EX/MEM boundary registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg      <= IDLE;
      acc_reg        <= '0;
      a_shift_reg    <= '0;
      b_shift_reg    <= '0;
      b_cap_reg      <= '0;
      cnt_reg        <= '0;
      rd_cap_reg     <= '0;
      rw_cap_reg     <= 1'b0;
      mr_cap_reg     <= 1'b0;
      mw_cap_reg     <= 1'b0;
      mulh_cap_reg   <= 1'b0;
      alu_result_out <= '0;
      store_data_out <= '0;
      rd_out         <= '0;
      reg_write_out  <= 1'b0;
      mem_read_out   <= 1'b0;
      mem_write_out  <= 1'b0;
    end else if (flush) begin
      // Killed instruction: no side effects downstream, any multiply is dropped.
      state_reg      <= IDLE;
      alu_result_out <= alu_result;
      store_data_out <= reg_data2_in;
      rd_out         <= '0;
      reg_write_out  <= 1'b0;
      mem_read_out   <= 1'b0;
      mem_write_out  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (is_mul) begin
            a_shift_reg    <= {{DATA_W{1'b0}}, reg_data1_in};
            b_shift_reg    <= reg_data2_in;
            b_cap_reg      <= reg_data2_in;
            acc_reg        <= '0;
            cnt_reg        <= '0;
            rd_cap_reg     <= rd_in;
            rw_cap_reg     <= reg_write_in;
            mr_cap_reg     <= mem_read_in;
            mw_cap_reg     <= mem_write_in;
            mulh_cap_reg   <= (alu_op_in == 4'hD);
            alu_result_out <= '0;
            store_data_out <= reg_data2_in;
            rd_out         <= '0;
            reg_write_out  <= 1'b0;
            mem_read_out   <= 1'b0;
            mem_write_out  <= 1'b0;
            state_reg      <= BUSY;
          end else begin
            alu_result_out <= alu_result;
            store_data_out <= reg_data2_in;
            rd_out         <= rd_in;
            reg_write_out  <= reg_write_in;
            mem_read_out   <= mem_read_in;
            mem_write_out  <= mem_write_in;
          end
        end
        BUSY: begin
          if (b_shift_reg[0]) begin
            acc_reg <= acc_reg + a_shift_reg;
          end
          a_shift_reg    <= a_shift_reg << 1;
          b_shift_reg    <= b_shift_reg >> 1;
          cnt_reg        <= cnt_reg + CNT_W'(1);
          alu_result_out <= '0;
          store_data_out <= reg_data2_in;
          rd_out         <= '0;
          reg_write_out  <= 1'b0;
          mem_read_out   <= 1'b0;
          mem_write_out  <= 1'b0;
          if (cnt_reg == LAST_CNT) begin
            state_reg <= DONE;
          end
        end
        DONE: begin
          // The held MUL in ID/EX retires here and is not restarted.
          alu_result_out <= mulh_cap_reg ? acc_reg[2*DATA_W-1:DATA_W] : acc_reg[DATA_W-1:0];
          store_data_out <= b_cap_reg;
          rd_out         <= rd_cap_reg;
          reg_write_out  <= rw_cap_reg;
          mem_read_out   <= mr_cap_reg;
          mem_write_out  <= mw_cap_reg;
          state_reg      <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
